// File: rtl/mem_stage_pipelined_pkg.sv
// Shared types for the MEM stage: load-mode and FSM state encodings, lane helpers.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    LM_WORD = 2'b00,
    LM_HALF = 2'b01,
    LM_BYTE = 2'b10
  } lm_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Byte-enable width for a given datapath width (DATA_W/8).
  function automatic int be_width(int dw);
    return dw / 8;
  endfunction

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic lm_t decode_lm(logic [1:0] m);
    case (m)
      2'b01:   return LM_HALF;
      2'b10:   return LM_BYTE;
      default: return LM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_pipelined_if.sv
// EX/MEM request and MEM/WB result bundle of the MEM stage.
interface mem_stage_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_flush;
  logic [ADDR_W-1:0] in_address;
  logic [DATA_W-1:0] in_write_data;
  logic              in_mem_read;
  logic              in_mem_write;
  logic [1:0]        in_load_mode;
  logic              in_load_unsigned;
  logic              in_mem_to_reg;
  logic              in_reg_write;
  logic              in_branch;
  logic              in_zero;
  logic [4:0]        in_write_back_destination;
  logic              stall_out;
  logic              pc_src;
  logic              valid_out;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] address_out;
  logic              mem_to_reg;
  logic              reg_write_out;
  logic [4:0]        write_back_destination_out;
  logic              misalign_out;

  modport master (
    output in_valid, in_flush, in_address, in_write_data, in_mem_read, in_mem_write,
           in_load_mode, in_load_unsigned, in_mem_to_reg, in_reg_write, in_branch,
           in_zero, in_write_back_destination,
    input  stall_out, pc_src, valid_out, read_data, address_out, mem_to_reg,
           reg_write_out, write_back_destination_out, misalign_out
  );

  modport slave (
    input  in_valid, in_flush, in_address, in_write_data, in_mem_read, in_mem_write,
           in_load_mode, in_load_unsigned, in_mem_to_reg, in_reg_write, in_branch,
           in_zero, in_write_back_destination,
    output stall_out, pc_src, valid_out, read_data, address_out, mem_to_reg,
           reg_write_out, write_back_destination_out, misalign_out
  );
endinterface

// File: rtl/mem_stage_pipelined_ram.sv
// Word-organised data RAM: synchronous read, per-byte write enable, no reset.
module mem_stage_ram
  import mem_stage_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int BEW    = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [BEW-1:0]    be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[idx];
    for (int b = 0; b < BEW; b++)
      if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end

endmodule

// File: rtl/mem_stage_pipelined.sv
// MIPS MEM stage: branch resolve, sized loads/stores with wait states, registered MEM/WB.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
//
// state   | meaning
// ST_IDLE | accepting EX/MEM; non-memory or zero-wait ops complete on the next edge
// ST_BUSY | multi-cycle access in flight; request latched, counter running down
module mem_stage_pipelined
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  mem_stage_pipelined_if.slave bus
);

  localparam int BEW    = be_width(DATA_W);
  localparam int LANE_W = $clog2(BEW);
  localparam int IDX_W  = $clog2(DEPTH);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd, r_wr, r_uns, r_m2r, r_rw;
  lm_t               r_mode;
  logic [4:0]        r_dest;

  logic              wb_valid, wb_rw, wb_m2r, wb_mis, ld_q, ld_uns;
  logic [4:0]        wb_dest;
  logic [DATA_W-1:0] wb_addr, ram_q, rd_ext;
  lm_t               ld_mode;
  logic [LANE_W-1:0] ld_lane;

  logic              busy, accept, start_wait, done, mis;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, ram_wdata;
  logic              c_rd, c_wr, c_uns, c_m2r, c_rw;
  lm_t               c_mode;
  logic [4:0]        c_dest;
  logic [LANE_W-1:0] c_lane;
  logic [BEW-1:0]    be, ram_be;
  logic [7:0]        rb;
  logic [15:0]       rh;

  // While busy the latched request is authoritative; otherwise EX/MEM is.
  assign busy    = (state == ST_BUSY);
  assign c_addr  = busy ? r_addr  : bus.in_address;
  assign c_wdata = busy ? r_wdata : bus.in_write_data;
  assign c_rd    = busy ? r_rd    : bus.in_mem_read;
  assign c_wr    = busy ? r_wr    : bus.in_mem_write;
  assign c_uns   = busy ? r_uns   : bus.in_load_unsigned;
  assign c_m2r   = busy ? r_m2r   : bus.in_mem_to_reg;
  assign c_rw    = busy ? r_rw    : bus.in_reg_write;
  assign c_mode  = busy ? r_mode  : decode_lm(bus.in_load_mode);
  assign c_dest  = busy ? r_dest  : bus.in_write_back_destination;
  assign c_lane  = c_addr[LANE_W-1:0];

  assign accept     = !busy && bus.in_valid && !bus.in_flush;
  assign start_wait = accept && (bus.in_mem_read || bus.in_mem_write) && (WAIT_CYCLES != 0);
  assign done       = busy ? (cnt == 4'd1 && !bus.in_flush) : (accept && !start_wait);

  assign bus.stall_out = start_wait || (busy && cnt != 4'd1);
  assign bus.pc_src    = bus.in_valid && bus.in_branch && bus.in_zero && !bus.in_flush;

`ifdef MISALIGN_TRAP_EN
  assign mis = done && (c_rd || c_wr) &&
               ((c_mode == LM_WORD && c_addr[1:0] != 2'b00) || (c_mode == LM_HALF && c_addr[0]));
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    be        = '0;
    ram_wdata = c_wdata;
    case (c_mode)
      LM_BYTE: begin
        be[c_lane] = 1'b1;
        ram_wdata  = {BEW{c_wdata[7:0]}};
      end
      LM_HALF: begin
        be[2*(c_lane >> 1) +: 2] = 2'b11;
        ram_wdata                = {(BEW/2){c_wdata[15:0]}};
      end
      default: be = '1;
    endcase
  end

  // Reset asserted on the completion edge must not let the write through.
  assign ram_be = (rst_n && done && c_wr && !mis) ? be : '0;

  mem_stage_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .re    (rst_n && done && c_rd && !c_wr && !mis),
    .be    (ram_be),
    .idx   (c_addr[IDX_W+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_uns    <= 1'b0;
      r_m2r    <= 1'b0;
      r_rw     <= 1'b0;
      r_mode   <= LM_WORD;
      r_dest   <= '0;
      wb_valid <= 1'b0;
      wb_rw    <= 1'b0;
      wb_m2r   <= 1'b0;
      wb_mis   <= 1'b0;
      wb_dest  <= '0;
      wb_addr  <= '0;
      ld_q     <= 1'b0;
      ld_uns   <= 1'b0;
      ld_mode  <= LM_WORD;
      ld_lane  <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_rw    <= 1'b0;
      wb_m2r   <= 1'b0;
      wb_mis   <= 1'b0;
      wb_dest  <= '0;
      wb_addr  <= '0;
      ld_q     <= 1'b0;
      case (state)
        ST_IDLE: if (start_wait) begin
          state   <= ST_BUSY;
          cnt     <= 4'(WAIT_CYCLES);
          r_addr  <= bus.in_address;
          r_wdata <= bus.in_write_data;
          r_rd    <= bus.in_mem_read;
          r_wr    <= bus.in_mem_write;
          r_uns   <= bus.in_load_unsigned;
          r_m2r   <= bus.in_mem_to_reg;
          r_rw    <= bus.in_reg_write;
          r_mode  <= decode_lm(bus.in_load_mode);
          r_dest  <= bus.in_write_back_destination;
        end
        ST_BUSY: if (bus.in_flush || cnt == 4'd1) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
      if (done) begin
        wb_valid <= 1'b1;
        wb_rw    <= c_rw && !mis;
        wb_m2r   <= c_m2r;
        wb_mis   <= mis;
        wb_dest  <= c_dest;
        wb_addr  <= DATA_W'(c_addr);
        ld_q     <= c_rd && !c_wr && !mis;
        ld_uns   <= c_uns;
        ld_mode  <= c_mode;
        ld_lane  <= c_lane;
      end
    end
  end

  always_comb begin
    rb     = ram_q[8*ld_lane +: 8];
    rh     = ram_q[16*(ld_lane >> 1) +: 16];
    rd_ext = '0;
    if (ld_q) begin
      case (ld_mode)
        LM_BYTE: rd_ext = {{(DATA_W-8){rb[7] & ~ld_uns}}, rb};
        LM_HALF: rd_ext = {{(DATA_W-16){rh[15] & ~ld_uns}}, rh};
        default: rd_ext = ram_q;
      endcase
    end
  end

  assign bus.valid_out                  = wb_valid;
  assign bus.read_data                  = rd_ext;
  assign bus.address_out                = wb_addr;
  assign bus.mem_to_reg                 = wb_m2r;
  assign bus.reg_write_out              = wb_rw;
  assign bus.write_back_destination_out = wb_dest;
  assign bus.misalign_out               = wb_mis;

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Self-checking bench for mem_stage_pipelined: vector table, scoreboard, hand-written corner sequences.
module tb_mem_stage_pipelined;

  localparam int DW = 32, AW = 32, DEPTH = 1024, W = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_pipelined_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  mem_stage_pipelined #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic rd, wr; logic [1:0] mode; logic uns; logic [31:0] addr, wdata;
    logic br, zero, flush, rw, m2r; logic [4:0] dest;
    logic [31:0] exp_rd; logic exp_pc, exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] rd, addr; logic rw, m2r, mis; logic [4:0] dest; int cyc, lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] mode, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic br, logic zero, logic flush, logic rw,
                              logic m2r, logic [4:0] dest, logic [31:0] exp_rd, logic exp_pc,
                              logic exp_mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mode = mode; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.br = br; v.zero = zero; v.flush = flush; v.rw = rw; v.m2r = m2r; v.dest = dest;
    v.exp_rd = exp_rd; v.exp_pc = exp_pc; v.exp_mis = exp_mis;
    return v;
  endfunction

  function automatic vec_t st(logic [1:0] mode, logic [31:0] addr, logic [31:0] data);
    return mk(0, 1, mode, 0, addr, data, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 0);
  endfunction

  function automatic vec_t ld(logic [1:0] mode, logic uns, logic [31:0] addr, logic [4:0] dest,
                              logic [31:0] exp_rd);
    return mk(1, 0, mode, uns, addr, 32'h0, 0, 0, 0, 1, 1, dest, exp_rd, 0, 0);
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_flush = 0; bus.in_address = '0; bus.in_write_data = '0;
    bus.in_mem_read = 0; bus.in_mem_write = 0; bus.in_load_mode = 2'b00;
    bus.in_load_unsigned = 0; bus.in_mem_to_reg = 0; bus.in_reg_write = 0;
    bus.in_branch = 0; bus.in_zero = 0; bus.in_write_back_destination = '0;
  endtask

  task automatic drive(vec_t v);
    bus.in_valid = 1; bus.in_flush = v.flush; bus.in_address = v.addr;
    bus.in_write_data = v.wdata; bus.in_mem_read = v.rd; bus.in_mem_write = v.wr;
    bus.in_load_mode = v.mode; bus.in_load_unsigned = v.uns; bus.in_mem_to_reg = v.m2r;
    bus.in_reg_write = v.rw; bus.in_branch = v.br; bus.in_zero = v.zero;
    bus.in_write_back_destination = v.dest;
  endtask

  task automatic issue(vec_t v);
    int stalls = 0;
    int exp_stalls;
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    chk("pc_src", 32'(bus.pc_src), 32'(v.exp_pc));
    if (!v.flush) begin
      e.rd = v.exp_rd; e.addr = v.addr; e.rw = v.rw & ~v.exp_mis; e.m2r = v.m2r;
      e.mis = v.exp_mis; e.dest = v.dest; e.cyc = cyc;
      e.lat = (v.rd || v.wr) ? W + 1 : 1;
      sb.push_back(e);
    end
    while (bus.stall_out && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (bus.stall_out) begin
      checks++; errors++;
      $display("FAIL stall_timeout: got stall_out 1 expected 0 after %0d cycles", stalls);
    end
    exp_stalls = ((v.rd || v.wr) && !v.flush) ? W : 0;
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(negedge clk);
    idle_inputs();
    if (v.flush) begin
      #1;
      chk("flush_bubble", 32'(bus.valid_out), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.valid_out) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got valid_out 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("read_data", bus.read_data, e.rd);
        chk("address_out", bus.address_out, e.addr);
        chk("reg_write_out", 32'(bus.reg_write_out), 32'(e.rw));
        chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(e.m2r));
        chk("wb_dest", 32'(bus.write_back_destination_out), 32'(e.dest));
        chk("misalign_out", 32'(bus.misalign_out), 32'(e.mis));
        chk("latency", 32'(cyc - e.cyc), 32'(e.lat));
      end
    end
  end

  initial begin
    vecs.push_back(st(2'b00, 32'h10, 32'hDEADBEEF));
    vecs.push_back(ld(2'b00, 0, 32'h10, 5'd5, 32'hDEADBEEF));
    vecs.push_back(st(2'b10, 32'h13, 32'h00000080));
    vecs.push_back(ld(2'b10, 0, 32'h13, 5'd6, 32'hFFFFFF80));
    vecs.push_back(ld(2'b10, 1, 32'h13, 5'd7, 32'h00000080));
    vecs.push_back(ld(2'b00, 0, 32'h10, 5'd8, 32'h80ADBEEF));
    vecs.push_back(ld(2'b01, 0, 32'h10, 5'd9, 32'hFFFFBEEF));
    vecs.push_back(ld(2'b11, 0, 32'h10, 5'd10, 32'h80ADBEEF));
    vecs.push_back(st(2'b00, 32'h20, 32'h55667788));
    vecs.push_back(st(2'b01, 32'h22, 32'h00001234));
    vecs.push_back(ld(2'b01, 0, 32'h22, 5'd11, 32'h00001234));
    vecs.push_back(ld(2'b00, 0, 32'h20, 5'd12, 32'h12347788));
    vecs.push_back(st(2'b00, 32'h40, 32'h11223344));
    vecs.push_back(st(2'b00, 32'h50, 32'h01010101));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h1234, 0, 0, 0, 0, 1, 0, 5'd7, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h0, 0, 1, 1, 0, 0, 0, 5'd0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h0, 0, 1, 1, 1, 0, 0, 5'd0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h0, 0, 1, 0, 0, 0, 0, 5'd0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 1, 2'b00, 0, 32'h30, 32'h0BADF00D, 0, 0, 0, 1, 1, 5'd3, 32'h0, 0, 0));
    vecs.push_back(ld(2'b00, 0, 32'h30, 5'd4, 32'h0BADF00D));

    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_valid_out", 32'(bus.valid_out), 32'h0);
    chk("rst_stall_out", 32'(bus.stall_out), 32'h0);
    chk("rst_read_data", bus.read_data, 32'h0);
    chk("rst_reg_write", 32'(bus.reg_write_out), 32'h0);
    chk("rst_misalign", 32'(bus.misalign_out), 32'h0);

    foreach (vecs[i]) issue(vecs[i]);

    // Flush while a store to 0x40 is waiting: RAM must keep 0x11223344.
    @(negedge clk);
    drive(st(2'b00, 32'h40, 32'hAAAA5555));
    #1 chk("flush_busy_stall0", 32'(bus.stall_out), 32'h1);
    @(negedge clk);
    bus.in_flush = 1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("flush_busy_idle", 32'(bus.stall_out), 32'h0);
    chk("flush_busy_valid", 32'(bus.valid_out), 32'h0);

    // Reset on the would-be completion edge of a store to 0x50.
    @(negedge clk);
    drive(st(2'b00, 32'h50, 32'h77777777));
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_mid_last_cycle", 32'(bus.stall_out), 32'h0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    #1;
    chk("rst_mid_stall", 32'(bus.stall_out), 32'h0);
    chk("rst_mid_valid", 32'(bus.valid_out), 32'h0);

    vecs.delete();
    vecs.push_back(ld(2'b00, 0, 32'h40, 5'd13, 32'h11223344));
    vecs.push_back(ld(2'b00, 0, 32'h50, 5'd14, 32'h01010101));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h41, 32'h5A5A5A5A, 0, 0, 0, 1, 0, 5'd15, 32'h0, 0, TRAP));
    vecs.push_back(ld(2'b00, 0, 32'h40, 5'd16, TRAP ? 32'h11223344 : 32'h5A5A5A5A));
    foreach (vecs[i]) issue(vecs[i]);

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish (checks %0d)", checks);
    $fatal(1, "timeout");
  end

endmodule
